// File: rtl/phys_rf_wb_pkg.sv
// phys_rf_wb_pkg: shared constants and the writeback entry type for the register file write arbiter.
// Ports: none (package).
package phys_rf_wb_pkg;
  localparam int PADDR_W   = 6;
  localparam int NUM_PREGS = 64;
  localparam int WB_DATA_W = 64;
  typedef struct packed {
    logic [PADDR_W-1:0]   paddr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/phys_rf_wb_fifo.sv
// phys_rf_wb_fifo: per-source result FIFO holding {paddr, data} entries.
// Ports: clk_i/rst_ni (sync, active-low), flush empties, push/pop (ignored when full/empty),
//        in_paddr/in_data write side, full/empty status, head_paddr/head_data oldest entry.
module phys_rf_wb_fifo
  import phys_rf_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [PADDR_W-1:0]    in_paddr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  full,
  output logic                  empty,
  output logic [PADDR_W-1:0]    head_paddr,
  output logic [DATA_WIDTH-1:0] head_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef struct packed {
    logic [PADDR_W-1:0]    paddr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;
  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          push_ok, pop_ok;
  assign full       = cnt == CW'(DEPTH);
  assign empty      = cnt == '0;
  assign push_ok    = push & ~full;
  assign pop_ok     = pop & ~empty;
  assign head_paddr = mem[rptr].paddr;
  assign head_data  = mem[rptr].data;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= '{paddr: in_paddr, data: in_data};
        wptr      <= wptr + 1'b1;
      end
      if (pop_ok) rptr <= rptr + 1'b1;
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/phys_rf_wb_arbiter.sv
// phys_rf_wb_arbiter: buffers FU writeback results per source and drains them round-robin onto RF write ports.
// Ports: clk_i/rst_ni (sync, active-low), flush_i discards buffered results,
//        wb_valid_i/wb_ready_o/wb_paddr_i/wb_data_i per-source handshake,
//        waddr_o/wdata_o/we_o registered RF write ports, busy_o pending work.
// Build option: PHYS_RF_WB_P0_DROP_EN accepts but silently discards results targeting paddr 0.
module phys_rf_wb_arbiter
  import phys_rf_wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int NR_WB_SRC      = 4,
  parameter int NR_WRITE_PORTS = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       flush_i,
  input  logic [NR_WB_SRC-1:0]                       wb_valid_i,
  output logic [NR_WB_SRC-1:0]                       wb_ready_o,
  input  logic [NR_WB_SRC-1:0][PADDR_W-1:0]          wb_paddr_i,
  input  logic [NR_WB_SRC-1:0][DATA_WIDTH-1:0]       wb_data_i,
  output logic [NR_WRITE_PORTS-1:0][PADDR_W-1:0]     waddr_o,
  output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wdata_o,
  output logic [NR_WRITE_PORTS-1:0]                  we_o,
  output logic                                       busy_o
);
  localparam int SW = NR_WB_SRC > 1 ? $clog2(NR_WB_SRC) : 1;
  logic [NR_WB_SRC-1:0]                  full, empty, keep, push, gnt;
  logic [NR_WB_SRC-1:0][PADDR_W-1:0]     head_paddr;
  logic [NR_WB_SRC-1:0][DATA_WIDTH-1:0]  head_data;
  logic [SW-1:0]                         rr_q, rr_nxt;
  logic [NR_WRITE_PORTS-1:0][SW-1:0]     port_src;
  logic [NR_WRITE_PORTS-1:0]             port_vld;
  assign wb_ready_o = rst_ni ? ~full : '0;
`ifdef PHYS_RF_WB_P0_DROP_EN
  // paddr 0 completes the handshake but is never enqueued
  always_comb for (int s = 0; s < NR_WB_SRC; s++) keep[s] = |wb_paddr_i[s];
`else
  assign keep = '1;
`endif
  assign push   = wb_valid_i & wb_ready_o & keep;
  assign busy_o = ~&empty | |we_o;
  for (genvar s = 0; s < NR_WB_SRC; s++) begin : g_fifo
    phys_rf_wb_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .flush     (flush_i),
      .push      (push[s]),
      .pop       (gnt[s]),
      .in_paddr  (wb_paddr_i[s]),
      .in_data   (wb_data_i[s]),
      .full      (full[s]),
      .empty     (empty[s]),
      .head_paddr(head_paddr[s]),
      .head_data (head_data[s])
    );
  end
  // Each port takes the first non-empty, not-yet-granted source in scan order from rr_q,
  // so port order matches scan order and rr_nxt ends just past the last grant.
  always_comb begin
    logic          found;
    logic [SW-1:0] idx;
    gnt      = '0;
    port_src = '0;
    port_vld = '0;
    rr_nxt   = rr_q;
    found    = 1'b0;
    idx      = '0;
    for (int p = 0; p < NR_WRITE_PORTS; p++) begin
      found = 1'b0;
      for (int i = 0; i < NR_WB_SRC; i++) begin
        idx = SW'((int'(rr_q) + i) % NR_WB_SRC);
        if (!found && !empty[idx] && !gnt[idx]) begin
          found       = 1'b1;
          gnt[idx]    = 1'b1;
          port_src[p] = idx;
          port_vld[p] = 1'b1;
          rr_nxt      = idx == SW'(NR_WB_SRC - 1) ? '0 : idx + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q    <= '0;
      we_o    <= '0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else if (flush_i) begin
      rr_q <= '0;
      we_o <= '0;
    end else begin
      rr_q <= rr_nxt;
      we_o <= port_vld;
      for (int p = 0; p < NR_WRITE_PORTS; p++) begin
        if (port_vld[p]) begin
          waddr_o[p] <= head_paddr[port_src[p]];
          wdata_o[p] <= head_data[port_src[p]];
        end
      end
    end
  end
endmodule

// File: tb/tb_phys_rf_wb_arbiter.sv
// tb_phys_rf_wb_arbiter: table-driven bench for phys_rf_wb_arbiter with hand-computed expectations.
module tb_phys_rf_wb_arbiter;
  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 flush = 1'b0;
  logic [3:0]           valid = '0;
  logic [3:0]           ready;
  logic [3:0][5:0]      paddr = '0;
  logic [3:0][63:0]     data = '0;
  logic [1:0][5:0]      waddr;
  logic [1:0][63:0]     wdata;
  logic [1:0]           we;
  logic                 busy;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic       rst_n;
    logic       flush;
    logic [3:0] valid;
    logic [5:0] base;
    logic [1:0] we;
    logic [5:0] a0;
    logic [5:0] a1;
    logic [3:0] ready;
    logic       busy;
  } vec_t;
  vec_t vecs[$];
  phys_rf_wb_arbiter dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .flush_i   (flush),
    .wb_valid_i(valid),
    .wb_ready_o(ready),
    .wb_paddr_i(paddr),
    .wb_data_i (data),
    .waddr_o   (waddr),
    .wdata_o   (wdata),
    .we_o      (we),
    .busy_o    (busy)
  );
  always #5 clk = ~clk;
  task automatic add(input logic r, input logic f, input logic [3:0] v, input logic [5:0] b,
                     input logic [1:0] w, input logic [5:0] a0, input logic [5:0] a1,
                     input logic [3:0] rd, input logic bz);
    vecs.push_back('{r, f, v, b, w, a0, a1, rd, bz});
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Source s drives paddr base+s with data 0xA0+paddr.
  task automatic drive(input vec_t t);
    rst_n = t.rst_n;
    flush = t.flush;
    valid = t.valid;
    for (int s = 0; s < 4; s++) begin
      paddr[s] = t.base + 6'(s);
      data[s]  = 64'hA0 + 64'(paddr[s]);
    end
  endtask
  initial begin
    //  rst flush valid    base we     a0  a1  ready    busy
    add(0, 0, 4'b0000, 0,  2'b00, 0,  0,  4'b0000, 0);  // reset
    add(1, 0, 4'b0000, 0,  2'b00, 0,  0,  4'b1111, 0);
    add(1, 0, 4'b0010, 4,  2'b00, 0,  0,  4'b1111, 1);  // single result src1 paddr5
    add(1, 0, 4'b0000, 0,  2'b01, 5,  0,  4'b1111, 1);
    add(1, 0, 4'b0000, 0,  2'b00, 0,  0,  4'b1111, 0);
    add(1, 1, 4'b0000, 0,  2'b00, 0,  0,  4'b1111, 0);  // flush -> rr 0
    add(1, 0, 4'b1111, 4,  2'b00, 0,  0,  4'b1111, 1);  // contention
    add(1, 0, 4'b1111, 8,  2'b11, 4,  5,  4'b1111, 1);
    add(1, 0, 4'b1111, 12, 2'b11, 6,  7,  4'b1111, 1);
    add(1, 0, 4'b1111, 16, 2'b11, 8,  9,  4'b1111, 1);
    add(1, 0, 4'b1111, 20, 2'b11, 10, 11, 4'b1111, 1);
    add(1, 0, 4'b1111, 24, 2'b11, 12, 13, 4'b0011, 1);
    add(1, 0, 4'b1111, 28, 2'b11, 14, 15, 4'b1100, 1);  // src2/3 full while popped
    add(1, 0, 4'b0000, 0,  2'b11, 16, 17, 4'b1111, 1);  // drain
    add(1, 0, 4'b0000, 0,  2'b11, 18, 19, 4'b1111, 1);
    add(1, 0, 4'b0000, 0,  2'b11, 20, 21, 4'b1111, 1);
    add(1, 0, 4'b0000, 0,  2'b11, 22, 23, 4'b1111, 1);
    add(1, 0, 4'b0000, 0,  2'b11, 24, 25, 4'b1111, 1);
    add(1, 0, 4'b0000, 0,  2'b11, 26, 27, 4'b1111, 1);
    add(1, 0, 4'b0000, 0,  2'b11, 28, 29, 4'b1111, 1);
    add(1, 0, 4'b0000, 0,  2'b00, 0,  0,  4'b1111, 0);
    add(1, 0, 4'b1111, 32, 2'b00, 0,  0,  4'b1111, 1);  // fill src2 to 3 entries, rr starts at 2
    add(1, 0, 4'b1111, 36, 2'b11, 34, 35, 4'b1111, 1);
    add(1, 0, 4'b1111, 40, 2'b11, 32, 33, 4'b1111, 1);
    add(1, 0, 4'b1111, 44, 2'b11, 38, 39, 4'b1111, 1);
    add(1, 0, 4'b1111, 48, 2'b11, 36, 37, 4'b1111, 1);
    add(1, 1, 4'b0001, 52, 2'b00, 0,  0,  4'b1111, 0);  // flush with concurrent push
    add(1, 0, 4'b0000, 0,  2'b00, 0,  0,  4'b1111, 0);
    add(1, 0, 4'b1111, 53, 2'b00, 0,  0,  4'b1111, 1);  // reset mid-stream
    add(1, 0, 4'b1111, 57, 2'b11, 53, 54, 4'b1111, 1);
    add(0, 0, 4'b1111, 0,  2'b00, 0,  0,  4'b0000, 0);
    add(1, 0, 4'b0000, 0,  2'b00, 0,  0,  4'b1111, 0);
    add(1, 0, 4'b0000, 0,  2'b00, 0,  0,  4'b1111, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      tick();
      chk($sformatf("v%0d_we", i), 64'(we), 64'(vecs[i].we));
      chk($sformatf("v%0d_ready", i), 64'(ready), 64'(vecs[i].ready));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].busy));
      if (vecs[i].we[0]) begin
        chk($sformatf("v%0d_waddr0", i), 64'(waddr[0]), 64'(vecs[i].a0));
        chk($sformatf("v%0d_wdata0", i), wdata[0], 64'hA0 + 64'(vecs[i].a0));
      end
      if (vecs[i].we[1]) begin
        chk($sformatf("v%0d_waddr1", i), 64'(waddr[1]), 64'(vecs[i].a1));
        chk($sformatf("v%0d_wdata1", i), wdata[1], 64'hA0 + 64'(vecs[i].a1));
      end
    end
    // Write a known entry, then reset must zero the held address/data registers.
    valid = 4'b0010; paddr[1] = 6'd9; data[1] = 64'hA9;
    tick();
    valid = '0;
    tick();
    chk("pre_rst_we", 64'(we), 64'h1);
    chk("pre_rst_waddr0", 64'(waddr[0]), 64'd9);
    chk("pre_rst_wdata0", wdata[0], 64'hA9);
    rst_n = 1'b0;
    tick();
    chk("rst_we", 64'(we), 64'h0);
    chk("rst_waddr0", 64'(waddr[0]), 64'h0);
    chk("rst_wdata0", wdata[0], 64'h0);
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", 64'(ready), 64'hF);
    // paddr 0 result
    valid = 4'b0001; paddr[0] = 6'd0; data[0] = 64'hFF;
    tick();
    valid = '0;
`ifdef PHYS_RF_WB_P0_DROP_EN
    chk("p0_busy", 64'(busy), 64'h0);
    tick();
    chk("p0_we", 64'(we), 64'h0);
`else
    chk("p0_busy", 64'(busy), 64'h1);
    tick();
    chk("p0_we", 64'(we), 64'h1);
    chk("p0_waddr0", 64'(waddr[0]), 64'h0);
    chk("p0_wdata0", wdata[0], 64'hFF);
`endif
    tick();
    chk("p0_we_after", 64'(we), 64'h0);
    chk("p0_busy_after", 64'(busy), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
